// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: default width, FSM encodings and
// the ALU opcode that selects the divide operation.
package div_pkg;

   localparam int WIDTH_DEFAULT = 32;

   // Control unit and ALU decode both key off this opcode
   localparam logic [3:0] DIV = 4'b0011;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      CALC = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {acc, q} left, try subtracting the divisor,
// keep the difference and set the quotient bit when it does not go negative.
module div_step
   import div_pkg::*;
#(
   parameter int W = WIDTH_DEFAULT
) (
   input  logic [W-1:0] acc_i,
   input  logic [W-1:0] q_i,
   input  logic [W-1:0] dvs_i,
   output logic [W-1:0] acc_o,
   output logic [W-1:0] q_o
);

   logic [W:0] shifted_s;
   logic [W:0] trial_s;

   // Trial subtraction carries one extra bit so its MSB is the borrow
   always_comb begin
      shifted_s = {acc_i, q_i[W-1]};
      trial_s   = shifted_s - {1'b0, dvs_i};
      if (!trial_s[W]) begin
         acc_o = trial_s[W-1:0];
         q_o   = {q_i[W-2:0], 1'b1};
      end else begin
         acc_o = shifted_s[W-1:0];
         q_o   = {q_i[W-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider with fixed WIDTH+2 latency; presents {remainder, quotient}
// on z_out and pulses done when the result is ready.
module seq_divider
   import div_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic               Clock,
   input  logic               clear,
   input  logic               start,
   input  logic               is_signed,
   input  logic [WIDTH-1:0]   dividend,
   input  logic [WIDTH-1:0]   divisor,
   output logic               busy,
   output logic               done,
   output logic               div_by_zero,
   output logic [2*WIDTH-1:0] z_out
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
   localparam logic [WIDTH-1:0] ZERO     = WIDTH'(0);

   div_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]   q_q, q_d;
   logic [WIDTH-1:0]   dvs_q, dvs_d;
   logic               sgn_q, sgn_d;
   logic               sq_q, sq_d;
   logic               sr_q, sr_d;
   logic [2*WIDTH-1:0] z_q, z_d;
   logic               dbz_q, dbz_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic               accept_s;
   logic [WIDTH-1:0]   step_acc_s;
   logic [WIDTH-1:0]   step_q_s;

   div_step #(.W(WIDTH)) u_step (
      .acc_i (acc_q),
      .q_i   (q_q),
      .dvs_i (dvs_q),
      .acc_o (step_acc_s),
      .q_o   (step_q_s)
   );

   // Next-state logic: FSM sequencing plus the datapath register updates for each phase
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      q_d      = q_q;
      dvs_d    = dvs_q;
      sgn_d    = sgn_q;
      sq_d     = sq_q;
      sr_d     = sr_q;
      z_d      = z_q;
      dbz_d    = dbz_q;
      accept_s = start && ((state_q == IDLE) || (state_q == DONE));

      case (state_q)
         IDLE, DONE: begin
            if (accept_s) begin
               state_d = LOAD;
               q_d     = dividend;
               dvs_d   = divisor;
               sgn_d   = is_signed;
               dbz_d   = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         LOAD: begin
            // Magnitudes wrap mod 2^WIDTH, so the most negative value maps to itself
            q_d     = (sgn_q && q_q[WIDTH-1])   ? (~q_q + ONE)   : q_q;
            dvs_d   = (sgn_q && dvs_q[WIDTH-1]) ? (~dvs_q + ONE) : dvs_q;
            sq_d    = sgn_q && (q_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
            sr_d    = sgn_q && q_q[WIDTH-1];
            acc_d   = ZERO;
            cnt_d   = CNT_LAST;
            state_d = CALC;
         end
         CALC: begin
            acc_d = step_acc_s;
            q_d   = step_q_s;
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == {CNT_W{1'b0}}) begin
               state_d = FIX;
            end else begin
               state_d = CALC;
            end
         end
         FIX: begin
            z_d     = {(sr_q ? (~acc_q + ONE) : acc_q), (sq_q ? (~q_q + ONE) : q_q)};
            dbz_d   = (dvs_q == ZERO);
            state_d = DONE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d == LOAD) || (state_d == CALC) || (state_d == FIX);
      done_d = (state_d == DONE);
   end

   // State and datapath registers; clear wipes everything immediately
   always_ff @(posedge Clock or negedge clear) begin
      if (!clear) begin
         state_q <= IDLE;
         cnt_q   <= {CNT_W{1'b0}};
         acc_q   <= ZERO;
         q_q     <= ZERO;
         dvs_q   <= ZERO;
         sgn_q   <= 1'b0;
         sq_q    <= 1'b0;
         sr_q    <= 1'b0;
         z_q     <= {(2*WIDTH){1'b0}};
         dbz_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         q_q     <= q_d;
         dvs_q   <= dvs_d;
         sgn_q   <= sgn_d;
         sq_q    <= sq_d;
         sr_q    <= sr_d;
         z_q     <= z_d;
         dbz_q   <= dbz_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign div_by_zero = dbz_q;
   assign z_out       = z_q;

endmodule
